// File: rtl/apb_slave_regs.sv
// APB3 completer with a small register bank: word 0 is a read-only ID, the others are read/write.
// A programmable number of wait states is inserted before pready, and bad accesses raise pslverr.
module apb_slave_regs #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [31:0]             wdata_q;
    logic                    err_q;
    logic                    pready_q;
    logic                    pslverr_q;
    logic [31:0]             prdata_q;
    logic [31:0]             regs_q [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   dec_addr;
    logic                    dec_write;
    logic [IDX_W-1:0]        dec_idx;
    logic [RIDX_W-1:0]       dec_ridx;
    logic                    dec_err;
    logic [31:0]             rd_word;
    logic [31:0]             resp_data;
    logic [RIDX_W-1:0]       wr_ridx;
    logic                    commit;

    // In IDLE the zero-wait response is built straight from the setup-phase bus values;
    // otherwise it comes from the latched copy. Either way it only feeds registers.
    always_comb begin
        dec_addr  = (state_q == ST_IDLE) ? paddr  : addr_q;
        dec_write = (state_q == ST_IDLE) ? pwrite : write_q;
        dec_idx   = dec_addr[ADDR_WIDTH-1:2];
        dec_ridx  = dec_addr[RIDX_W+1:2];
        dec_err   = (dec_addr[1:0] != 2'b00)
                 || (dec_idx >= IDX_W'(NUM_REGS))
                 || (dec_write && (dec_idx == '0));
        rd_word   = (dec_ridx == '0) ? ID_VALUE : regs_q[dec_ridx];
        if (dec_err) begin
            resp_data = 32'h0;
        end else if (dec_write) begin
            resp_data = prdata_q;
        end else begin
            resp_data = rd_word;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        cnt_q   <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state_q   <= ST_RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= dec_err;
                            err_q     <= dec_err;
                            prdata_q  <= resp_data;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        state_q <= ST_IDLE;
                    end else if (penable) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q   <= ST_RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= dec_err;
                            err_q     <= dec_err;
                            prdata_q  <= resp_data;
                        end
                    end
                end
                ST_RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Writes land at the closing edge of the response cycle, so a follow-on read sees them.
    assign commit  = (state_q == ST_RESP) && write_q && !err_q;
    assign wr_ridx = addr_q[RIDX_W+1:2];

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (commit) begin
            regs_q[wr_ridx] <= wdata_q;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule
